// File: rtl/of_stage.sv
// rtl/of_stage.sv - SimpleRISC operand-fetch stage: IF/OF register, decode, 16x32 register file, immediate and branch target.
// Optional write-through forwarding from writeback into op1/op2: define OF_WB_BYPASS_EN.
module of_stage #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] NOP_INSTR = 32'h6800_0000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        isBranchTaken,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        of_valid,
    output logic [31:0] of_pc,
    output logic [31:0] of_instr,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [31:0] immx,
    output logic [31:0] branchTarget,
    output logic [3:0]  rd_out,
    output logic        isImmediate
);

    localparam logic [4:0] OPC_ST   = 5'b01111;
    localparam logic [4:0] OPC_CALL = 5'b10011;
    localparam logic [4:0] OPC_RET  = 5'b10100;

    logic [31:0] r_regs [NUM_REGS];

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_immx;
    logic [31:0] r_bt;
    logic [3:0]  r_rd;
    logic        r_isimm;

    logic [4:0]  w_opcode;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic [3:0]  w_rd;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_immx;
    logic [31:0] w_bt;

    assign w_opcode = instr_in[31:27];
    assign w_rs1    = (w_opcode == OPC_RET)  ? 4'd15 : instr_in[21:18];
    assign w_rs2    = (w_opcode == OPC_ST)   ? instr_in[25:22] : instr_in[17:14];
    assign w_rd     = (w_opcode == OPC_CALL) ? 4'd15 : instr_in[25:22];
    assign w_bt     = pc_in + {{3{instr_in[26]}}, instr_in[26:0], 2'b00};

    always_comb begin
        w_op1 = r_regs[w_rs1];
        w_op2 = r_regs[w_rs2];
`ifdef OF_WB_BYPASS_EN
        if (wb_en && (wb_rd == w_rs1)) w_op1 = wb_data;
        if (wb_en && (wb_rd == w_rs2)) w_op2 = wb_data;
`endif
    end

    always_comb begin
        w_immx = {{16{instr_in[15]}}, instr_in[15:0]};
        case (instr_in[17:16])
            2'b01:   w_immx = {16'h0000, instr_in[15:0]};
            2'b10:   w_immx = {instr_in[15:0], 16'h0000};
            default: w_immx = {{16{instr_in[15]}}, instr_in[15:0]};
        endcase
    end

    // Writeback is independent of stall/flush; reads above see the pre-edge contents.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (wb_en) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset || isBranchTaken) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_op1   <= '0;
            r_op2   <= '0;
            r_immx  <= '0;
            r_bt    <= '0;
            r_rd    <= '0;
            r_isimm <= 1'b0;
        end else if (!stall) begin
            r_valid <= 1'b1;
            r_pc    <= pc_in;
            r_instr <= instr_in;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_immx  <= w_immx;
            r_bt    <= w_bt;
            r_rd    <= w_rd;
            r_isimm <= instr_in[26];
        end
    end

    assign of_valid     = r_valid;
    assign of_pc        = r_pc;
    assign of_instr     = r_instr;
    assign op1          = r_op1;
    assign op2          = r_op2;
    assign immx         = r_immx;
    assign branchTarget = r_bt;
    assign rd_out       = r_rd;
    assign isImmediate  = r_isimm;

endmodule

// File: tb/tb_of_stage.sv
// tb/tb_of_stage.sv - directed plus random scoreboard bench for of_stage.
module tb_of_stage;

    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        isBranchTaken = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        of_valid;
    logic [31:0] of_pc, of_instr, op1, op2, immx, branchTarget;
    logic [3:0]  rd_out;
    logic        isImmediate;

    of_stage dut (
        .Clk(Clk), .reset(reset), .stall(stall), .isBranchTaken(isBranchTaken),
        .pc_in(pc_in), .instr_in(instr_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .of_valid(of_valid), .of_pc(of_pc), .of_instr(of_instr), .op1(op1), .op2(op2),
        .immx(immx), .branchTarget(branchTarget), .rd_out(rd_out), .isImmediate(isImmediate)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] immx;
        logic [31:0] bt;
        logic [3:0]  rd;
        logic        isimm;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last;
    logic [31:0] m_regs [16];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t reset_val();
        exp_t e;
        e = '0;
        e.instr = NOP;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic we, input logic [3:0] wa, input logic [31:0] wd);
        exp_t e;
        logic [3:0] a1, a2;
        a1 = (instr[31:27] == 5'b10100) ? 4'd15 : instr[21:18];
        a2 = (instr[31:27] == 5'b01111) ? instr[25:22] : instr[17:14];
        e.valid = 1'b1;
        e.pc    = pc;
        e.instr = instr;
        e.op1   = m_regs[a1];
        e.op2   = m_regs[a2];
        if (we && wa == a1 && 1'b0) e.op1 = wd;
`ifdef OF_WB_BYPASS_EN
        if (we && wa == a1) e.op1 = wd;
        if (we && wa == a2) e.op2 = wd;
`endif
        case (instr[17:16])
            2'b01:   e.immx = {16'h0, instr[15:0]};
            2'b10:   e.immx = {instr[15:0], 16'h0};
            default: e.immx = {{16{instr[15]}}, instr[15:0]};
        endcase
        e.bt    = pc + {{3{instr[26]}}, instr[26:0], 2'b00};
        e.rd    = (instr[31:27] == 5'b10011) ? 4'd15 : instr[25:22];
        e.isimm = instr[26];
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        cmp({tag, ".valid"}, 32'(of_valid), 32'(e.valid));
        cmp({tag, ".pc"}, of_pc, e.pc);
        cmp({tag, ".instr"}, of_instr, e.instr);
        cmp({tag, ".op1"}, op1, e.op1);
        cmp({tag, ".op2"}, op2, e.op2);
        cmp({tag, ".immx"}, immx, e.immx);
        cmp({tag, ".bt"}, branchTarget, e.bt);
        cmp({tag, ".rd"}, 32'(rd_out), 32'(e.rd));
        cmp({tag, ".isimm"}, 32'(isImmediate), 32'(e.isimm));
    endtask

    // Called at posedge+1; drives one edge worth of inputs and checks the result at the next posedge+1.
    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic st, input logic fl,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd);
        exp_t e;
        exp_t got;
        pc_in = pc; instr_in = instr; stall = st; isBranchTaken = fl;
        wb_en = we; wb_rd = wa; wb_data = wd;
        if (fl)      e = reset_val();
        else if (st) e = last;
        else         e = model(pc, instr, we, wa, wd);
        sb_q.push_back(e);
        last = e;
        if (we) m_regs[wa] = wd;
        @(posedge Clk);
        #1;
        wb_en = 1'b0; isBranchTaken = 1'b0; stall = 1'b0;
        if (sb_q.size() == 0) begin
            cmp({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_outputs(tag, got);
        end
    endtask

    task automatic wr(input logic [3:0] wa, input logic [31:0] wd);
        step("wr", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, wa, wd);
    endtask

    logic [31:0] imm_exp [4];
    logic [31:0] ins;

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        last = reset_val();
        imm_exp[0] = 32'hFFFF_FFFE; imm_exp[1] = 32'h0000_FFFE;
        imm_exp[2] = 32'hFFFE_0000; imm_exp[3] = 32'hFFFF_FFFE;

        @(posedge Clk); #1;
        check_outputs("por", reset_val());
        reset = 1'b1;

        wr(4'd3, 32'h0000_00AA);
        wr(4'd4, 32'h0000_0055);
        // add r1, r3, r4
        step("add", 32'h10, 32'h004D_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("add.op1c", op1, 32'hAA);
        cmp("add.op2c", op2, 32'h55);
        cmp("add.rdc", 32'(rd_out), 32'd1);
        cmp("add.validc", 32'(of_valid), 32'd1);

        for (int m = 0; m < 4; m++) begin
            ins = 32'h0400_FFFE | (32'(m) << 16);
            step("imm", 32'h14, ins, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
            cmp("imm.c", immx, imm_exp[m]);
        end

        step("b", 32'h20, {5'b10010, 27'h7FF_FFFF}, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("b.btc", branchTarget, 32'h1C);
        step("call", 32'h20, {5'b10011, 27'h7FF_FFFF}, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("call.rdc", 32'(rd_out), 32'd15);
        cmp("call.btc", branchTarget, 32'h1C);

        wr(4'd15, 32'h0000_1234);
        wr(4'd7, 32'h0000_7777);
        step("ret", 32'h30, {5'b10100, 27'h0}, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("ret.op1c", op1, 32'h1234);
        step("st", 32'h34, {5'b01111, 1'b1, 4'd7, 4'd3, 2'b00, 16'h0008}, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("st.op2c", op2, 32'h7777);

        step("stall0", 32'h40, 32'h004D_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step("stall", 32'h44 + 32'(k * 4), 32'h1234_5678 + 32'(k), 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
            cmp("stall.pcc", of_pc, 32'h40);
        end
        step("flush", 32'h50, 32'h004D_0000, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
        cmp("flush.validc", 32'(of_valid), 32'd0);
        cmp("flush.instrc", of_instr, NOP);

        wr(4'd5, 32'h1111_2222);
        step("byp", 32'h60, 32'h0014_0000, 1'b0, 1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF);
`ifdef OF_WB_BYPASS_EN
        cmp("byp.op1c", op1, 32'hDEAD_BEEF);
`else
        cmp("byp.op1c", op1, 32'h1111_2222);
`endif
        step("byp2", 32'h64, 32'h0014_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("byp2.op1c", op1, 32'hDEAD_BEEF);

        for (int r = 0; r < 12; r++) begin
            step("rnd", $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom);
        end

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2 reset = 1'b0;
        #1;
        check_outputs("arst", reset_val());
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        last = reset_val();
        @(posedge Clk); #1;
        reset = 1'b1;
        step("post", 32'h70, 32'h004D_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        cmp("post.op1c", op1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
